y86_regfile_sb: RTL and testbench

Parametrised, scoreboarded register file for the pipelined Y86 core, replacing the flat sequential-core register file. It provides two combinational read ports (srcA/srcB) and two writeback ports (E and M), with optional write-to-read bypass. A per-register pending-write scoreboard is reserved at issue, retired at writeback, and drives a decode-stage stall. It sits between the decode stage (reads, issue reservations) and the writeback stage (writes).

---
 rtl/y86_rf_pkg.sv | 40 ++++
 rtl/y86_rf_pend_ctr.sv | 38 +++
 rtl/y86_regfile_sb.sv | 152 +++++++++++++++
 tb/tb_y86_regfile_sb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/y86_rf_pkg.sv
// Shared definitions for the Y86 scoreboarded register file: default
// parameter values, architectural register indices and the RNONE helper.
// The optional same-cycle write-to-read bypass is selected in the top
// level by the RF_BYPASS_EN macro.
package y86_rf_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_RW     = 4;
  localparam int DEF_PEND_W = 2;

  // Widest register index the is_none helper accepts.
  localparam int MAX_RW = 8;

  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  // True when idx (zero-extended from an rw-bit index) is the all-ones
  // "no register" encoding for that index width.
  function automatic logic is_none(input logic [MAX_RW-1:0] idx,
                                   input int unsigned rw);
    logic [MAX_RW-1:0] mask;
    mask = MAX_RW'((64'd1 << rw) - 64'd1);
    return idx == mask;
  endfunction

endpackage

// File: rtl/y86_rf_pend_ctr.sv
// One pending-write counter of the register-file scoreboard. Increments on
// an issue reservation, decrements on a writeback, saturates at both ends
// and flags the saturating attempt on err for the cycle it happens.
module y86_rf_pend_ctr
  import y86_rf_pkg::*;
#(
  parameter int W = DEF_PEND_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic is_one,
  output logic err
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt;

  // Up/down count; simultaneous inc and dec cancel, ends saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero = |cnt;
  assign is_one  = (cnt == W'(1));
  assign err     = (inc && !dec && (cnt == CNT_MAX)) ||
                   (dec && !inc && (cnt == '0));

endmodule

// File: rtl/y86_regfile_sb.sv
// Scoreboarded register file for the pipelined Y86 core: two combinational
// read ports, two writeback ports (M wins on a shared destination), and a
// per-register pending-write counter that drives the decode stall.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read
// ports and to let a final pending write resolve the stall in its
// writeback cycle.
//
// Issue interface: iss_valid is a one-cycle strobe with no ready; every
// cycle it is high, iss_dstE/iss_dstM (non-RNONE) are reserved at that
// rising edge. Holding issue while stall is high is the caller's job.
module y86_regfile_sb
  import y86_rf_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RW     = DEF_RW,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   srcA,
  input  logic [RW-1:0]   srcB,
  output logic [XLEN-1:0] valA,
  output logic [XLEN-1:0] valB,
  input  logic [RW-1:0]   dstE,
  input  logic [XLEN-1:0] valE,
  input  logic [RW-1:0]   dstM,
  input  logic [XLEN-1:0] valM,
  input  logic            iss_valid,
  input  logic [RW-1:0]   iss_dstE,
  input  logic [RW-1:0]   iss_dstM,
  output logic            stall,
  output logic            sb_err
);

  localparam int NREGS = (1 << RW) - 1;
  localparam int NSLOT = 1 << RW;

`ifdef RF_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic [XLEN-1:0]  regs [NREGS];
  logic [NSLOT-1:0] pend_nz;
  logic [NSLOT-1:0] pend_one;
  logic [NREGS-1:0] pend_err;

  logic none_a, none_b, none_e, none_m;
  logic we_e;
  logic [XLEN-1:0] rd_a, rd_b;
  logic hit_a, hit_b;
  logic res_a, res_b;

  assign none_a = is_none(MAX_RW'(srcA), RW);
  assign none_b = is_none(MAX_RW'(srcB), RW);
  assign none_e = is_none(MAX_RW'(dstE), RW);
  assign none_m = is_none(MAX_RW'(dstM), RW);

  // E writes only when M is not targeting the same register.
  assign we_e = !none_e && (dstE != dstM);

  // The RNONE slot has no counter; it never reports pending.
  assign pend_nz[NSLOT-1]  = 1'b0;
  assign pend_one[NSLOT-1] = 1'b0;

  // Register array: clear on reset, otherwise E then M writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (we_e) begin
        regs[dstE] <= valE;
      end
      if (!none_m) begin
        regs[dstM] <= valM;
      end
    end
  end

  // Read port A: array value, optionally overridden by same-cycle writeback.
  always_comb begin
    rd_a = '0;
    if (!none_a) begin
      rd_a = regs[srcA];
      if (BYP_EN) begin
        if (srcA == dstM) begin
          rd_a = valM;
        end else if (srcA == dstE) begin
          rd_a = valE;
        end
      end
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rd_b = '0;
    if (!none_b) begin
      rd_b = regs[srcB];
      if (BYP_EN) begin
        if (srcB == dstM) begin
          rd_b = valM;
        end else if (srcB == dstE) begin
          rd_b = valE;
        end
      end
    end
  end

  assign valA = rst ? '0 : rd_a;
  assign valB = rst ? '0 : rd_b;

  // A source is resolved when its last outstanding write is on a
  // writeback port this cycle and bypass can deliver it.
  assign res_a = BYP_EN && pend_one[srcA] && ((dstE == srcA) || (dstM == srcA));
  assign res_b = BYP_EN && pend_one[srcB] && ((dstE == srcB) || (dstM == srcB));

  assign hit_a = !none_a && pend_nz[srcA] && !res_a;
  assign hit_b = !none_b && pend_nz[srcB] && !res_b;

  assign stall = !rst && (hit_a || hit_b);

  // One pending counter per architectural register.
  for (genvar r = 0; r < NREGS; r++) begin : g_pend
    logic inc, dec;
    assign inc = iss_valid && ((iss_dstE == RW'(r)) || (iss_dstM == RW'(r)));
    assign dec = (dstE == RW'(r)) || (dstM == RW'(r));

    y86_rf_pend_ctr #(.W(PEND_W)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .dec     (dec),
      .nonzero (pend_nz[r]),
      .is_one  (pend_one[r]),
      .err     (pend_err[r])
    );
  end

  // Sticky scoreboard error: any counter overflow/underflow until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|pend_err) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Self-checking bench for y86_regfile_sb with default parameters.
// Expectations follow the RF_BYPASS_EN setting of the build.
module tb_y86_regfile_sb;

  localparam logic [3:0] N = 4'hF;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic        iv;
    logic [3:0]  ie;
    logic [3:0]  im;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        es;
    logic        ee;
    logic        ce;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  srcA, srcB, dstE, dstM, iss_dstE, iss_dstM;
  logic [63:0] valA, valB, valE, valM;
  logic        iss_valid;
  logic        stall;
  logic        sb_err;

  logic [63:0] exp_q[$];
  int          checks;
  int          failures;
  vec_t        tbl[15];

  y86_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .srcA      (srcA),
    .srcB      (srcB),
    .valA      (valA),
    .valB      (valB),
    .dstE      (dstE),
    .valE      (valE),
    .dstM      (dstM),
    .valM      (valM),
    .iss_valid (iss_valid),
    .iss_dstE  (iss_dstE),
    .iss_dstM  (iss_dstM),
    .stall     (stall),
    .sb_err    (sb_err)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic iv, input logic [3:0] ie, input logic [3:0] im,
                              input logic [63:0] ea, input logic [63:0] eb,
                              input logic es, input logic ee, input logic ce);
    vec_t v;
    v.rst = r;  v.sa = sa; v.sb = sb; v.de = de; v.ve = ve; v.dm = dm; v.vm = vm;
    v.iv = iv;  v.ie = ie; v.im = im; v.ea = ea; v.eb = eb; v.es = es; v.ee = ee;
    v.ce = ce;
    return v;
  endfunction

  // Scoreboard compare: pop the oldest expectation and check it.
  task automatic chk(input string nm, input logic [63:0] act);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: actual=%h, no expected value queued", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s: actual=%h expected=%h", nm, act, e);
      end
    end
  endtask

  // Driver: apply one cycle of stimulus, check at the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    rst       = v.rst;
    srcA      = v.sa;
    srcB      = v.sb;
    dstE      = v.de;
    valE      = v.ve;
    dstM      = v.dm;
    valM      = v.vm;
    iss_valid = v.iv;
    iss_dstE  = v.ie;
    iss_dstM  = v.im;
    exp_q.push_back(v.ea);
    exp_q.push_back(v.eb);
    exp_q.push_back({63'd0, v.es});
    if (v.ce) exp_q.push_back({63'd0, v.ee});
    @(negedge clk);
    chk($sformatf("%s.valA", tag), valA);
    chk($sformatf("%s.valB", tag), valB);
    chk($sformatf("%s.stall", tag), {63'd0, stall});
    if (v.ce) chk($sformatf("%s.sb_err", tag), {63'd0, sb_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with junk on every input; outputs forced to zero meanwhile.
    run_vec(mk(1, 2, 7, 4, 64'h99, 5, 64'h98, 1, 6, 7, 0, 0, 0, 0, 0), "rst0");
    run_vec(mk(1, 4, 5, N, 0, N, 0, 0, N, N, 0, 0, 0, 0, 1), "rst1");

    // Every register reads zero after reset.
    for (int r = 0; r < 15; r++) begin
      run_vec(mk(0, 4'(r), 4'(14 - r), N, 0, N, 0, 0, N, N, 0, 0, 0, 0, 1),
              $sformatf("clr%0d", r));
    end
    run_vec(mk(0, N, N, N, 0, N, 0, 0, N, N, 0, 0, 0, 0, 1), "rnone");

    // Table: reservations, writebacks, M priority, stall and inc/dec cancel.
    tbl[0]  = mk(0, 0, 2,  N, 0,        N, 0,        1, 1,  3, 0,        0,     0, 0, 1);
    tbl[1]  = mk(0, 4, 5,  1, 64'h7,    3, 64'h33,   0, N,  N, 0,        0,     0, 0, 1);
    tbl[2]  = mk(0, 1, 3,  N, 0,        N, 0,        0, N,  N, 64'h7,    64'h33, 0, 0, 1);
    tbl[3]  = mk(0, 1, N,  N, 0,        N, 0,        1, 3,  3, 64'h7,    0,     0, 0, 1);
    tbl[4]  = mk(0, 3, 1,  N, 0,        N, 0,        0, N,  N, 64'h33,   64'h7, 1, 0, 1);
    tbl[5]  = mk(0, 1, 2,  3, 64'h55,   3, 64'hAA,   0, N,  N, 64'h7,    0,     0, 0, 1);
    tbl[6]  = mk(0, 3, N,  N, 0,        N, 0,        0, N,  N, 64'hAA,   0,     0, 0, 1);
    tbl[7]  = mk(0, 8, 9,  N, 0,        N, 0,        1, 8,  N, 0,        0,     0, 0, 1);
    tbl[8]  = mk(0, 9, 8,  N, 0,        N, 0,        1, 8,  N, 0,        0,     1, 0, 1);
    tbl[9]  = mk(0, 9, 10, 8, 64'h1111, N, 0,        0, N,  N, 0,        0,     0, 0, 1);
    tbl[10] = mk(0, 8, N,  N, 0,        N, 0,        0, N,  N, 64'h1111, 0,     1, 0, 1);
    tbl[11] = mk(0, 0, 1,  N, 0,        8, 64'h2222, 0, N,  N, 0,        64'h7, 0, 0, 1);
    tbl[12] = mk(0, 8, 3,  N, 0,        N, 0,        0, N,  N, 64'h2222, 64'hAA, 0, 0, 1);
    tbl[13] = mk(0, 0, 0,  10, 64'h10,  N, 0,        1, 10, N, 0,        0,     0, 0, 1);
    tbl[14] = mk(0, 10, N, N, 0,        N, 0,        0, N,  N, 64'h10,   0,     0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Same-cycle read of a register being written back (reg 1 holds 7).
    run_vec(mk(0, N, N, N, 0, N, 0, 1, 1, N, 0, 0, 0, 0, 1), "byp_iss");
    run_vec(mk(0, 1, N, 1, 64'h9, N, 0, 0, N, N, BYP ? 64'h9 : 64'h7, 0, !BYP, 0, 1), "byp_wb");
    run_vec(mk(0, 1, N, N, 0, N, 0, 0, N, N, 64'h9, 0, 0, 0, 1), "byp_next");

    // Stall on reg 2 from reservation until its writeback resolves.
    run_vec(mk(0, N, N, N, 0, N, 0, 1, 2, N, 0, 0, 0, 0, 1), "st_iss");
    run_vec(mk(0, N, 2, N, 0, N, 0, 0, N, N, 0, 0, 1, 0, 1), "st_pend");
    run_vec(mk(0, N, 2, 2, 64'h22, N, 0, 0, N, N, 0, BYP ? 64'h22 : 64'h0, !BYP, 0, 1), "st_wb");
    run_vec(mk(0, N, 2, N, 0, N, 0, 0, N, N, 0, 64'h22, 0, 0, 1), "st_after");

    // Overflow: four reservations on reg 5 saturate the counter at 3.
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(0, N, N, N, 0, N, 0, 1, 5, N, 0, 0, 0, 0, 1), $sformatf("ov_iss%0d", i));
    end
    run_vec(mk(0, 5, N, N, 0, N, 0, 1, 5, N, 0, 0, 1, 0, 1), "ov_iss3");
    run_vec(mk(0, 5, N, N, 0, N, 0, 0, N, N, 0, 0, 1, 1, 1), "ov_err");
    run_vec(mk(0, N, N, 5, 64'h5, N, 0, 0, N, N, 0, 0, 0, 1, 1), "ov_wb0");
    run_vec(mk(0, N, N, 5, 64'h5, N, 0, 0, N, N, 0, 0, 0, 1, 1), "ov_wb1");
    run_vec(mk(0, 5, N, N, 0, N, 0, 0, N, N, 64'h5, 0, 1, 1, 1), "ov_left1");
    run_vec(mk(1, 5, N, N, 0, N, 0, 0, N, N, 0, 0, 0, 1, 1), "ov_rst");
    run_vec(mk(0, 5, N, N, 0, N, 0, 0, N, N, 0, 0, 0, 0, 1), "ov_clear");

    // Underflow: writeback to reg 6 with nothing pending.
    run_vec(mk(0, N, N, N, 0, 6, 64'h66, 0, N, N, 0, 0, 0, 0, 1), "uf_wb");
    run_vec(mk(0, 6, N, N, 0, N, 0, 0, N, N, 64'h66, 0, 0, 1, 1), "uf_data");
    run_vec(mk(0, 6, N, N, 0, N, 0, 1, 6, N, 64'h66, 0, 0, 1, 1), "uf_iss");
    run_vec(mk(0, 6, N, N, 0, N, 0, 0, N, N, 64'h66, 0, 1, 1, 1), "uf_pend");
    run_vec(mk(0, N, N, 6, 64'h67, N, 0, 0, N, N, 0, 0, 0, 1, 1), "uf_wb2");
    run_vec(mk(0, 6, N, N, 0, N, 0, 0, N, N, 64'h67, 0, 0, 1, 1), "uf_done");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: queued=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
